// File: rtl/axi_wr_resp_slave_pkg.sv
// Shared AXI encodings, FSM state type and the AW legality check for the
// memory-backed write responder.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

package axi_wr_resp_slave_pkg;

  // Burst type encodings
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Only full 32-bit beats are supported by the SRAM port
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_RESP  = 2'd2
  } wr_state_e;

  // Flags an AW request this slave cannot service. Arithmetic is 33 bits
  // wide so a burst ending past 4 GiB still compares as out of window.
  function automatic logic aw_illegal(
    input logic [31:0] addr,
    input logic [3:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  burst,
    input logic [31:0] base,
    input int          mab
  );
    logic [32:0] start_b;
    logic [32:0] last_b;
    logic [32:0] win_lo;
    logic [32:0] win_hi;
    start_b = {1'b0, addr};
    last_b  = start_b + (({29'd0, len} + 33'd1) << 2) - 33'd1;
    win_lo  = {1'b0, base};
    win_hi  = win_lo + (33'd4 << mab) - 33'd1;
    return (size != SIZE_WORD)
         | ((burst != BURST_FIXED) && (burst != BURST_INCR))
         | (addr[1:0] != 2'b00)
         | (start_b < win_lo)
         | (last_b > win_hi);
  endfunction

endpackage

// File: rtl/axi_wr_resp_slave_wr_addr_gen.sv
// Per-beat SRAM word address and beat counter for one write burst, plus
// detection of a WLAST that disagrees with the latched AWLEN.
module axi_wr_resp_slave_wr_addr_gen
  import axi_wr_resp_slave_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic [MEM_ADDR_BITS-1:0] start_addr_i,
  input  logic [3:0]               len_i,
  input  logic [1:0]               burst_i,
  input  logic                     beat_i,
  input  logic                     last_i,
  output logic [MEM_ADDR_BITS-1:0] addr_o,
  output logic                     len_err_o,
  output logic                     early_last_o
);

  logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [3:0]               count_q, count_d;
  logic [3:0]               len_q, len_d;
  logic [1:0]               burst_q, burst_d;

  assign addr_o = addr_q;

  // WLAST before the final beat: the beat carrying it must not be written
  assign early_last_o = last_i & (count_q != len_q);

  // Either WLAST too early, or the final counted beat arrived without WLAST
  assign len_err_o = beat_i & (last_i ? (count_q != len_q) : (count_q == len_q));

  // Load on AW acceptance, step address (INCR only) and count on each beat
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    len_d   = len_q;
    burst_d = burst_q;
    if (load_i) begin
      addr_d  = start_addr_i;
      count_d = 4'd0;
      len_d   = len_i;
      burst_d = burst_i;
    end else if (beat_i) begin
      if (burst_q == BURST_INCR) begin
        addr_d = addr_q + MEM_ADDR_BITS'(1);
      end
      count_d = count_q + 4'd1;
    end
  end

  // Burst tracking registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= 4'd0;
      len_q   <= 4'd0;
      burst_q <= BURST_FIXED;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      len_q   <= len_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/axi_wr_resp_slave.sv
// AXI slave write responder: accepts one AW/W burst at a time, writes the
// beats into a single-port SRAM and returns a B response.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

module axi_wr_resp_slave
  import axi_wr_resp_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0001_0000,
  parameter int          MEM_ADDR_BITS = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [`AXI_IDS_BITS-1:0] awid_i,
  input  logic [31:0]              awaddr_i,
  input  logic [3:0]               awlen_i,
  input  logic [2:0]               awsize_i,
  input  logic [1:0]               awburst_i,
  input  logic                     awvalid_i,
  output logic                     awready_o,
  input  logic [31:0]              wdata_i,
  input  logic [3:0]               wstrb_i,
  input  logic                     wlast_i,
  input  logic                     wvalid_i,
  output logic                     wready_o,
  output logic [`AXI_IDS_BITS-1:0] bid_o,
  output logic [1:0]               bresp_o,
  output logic                     bvalid_o,
  input  logic                     bready_i,
  output logic                     mem_cs_o,
  output logic [3:0]               mem_we_o,
  output logic [MEM_ADDR_BITS-1:0] mem_addr_o,
  output logic [31:0]              mem_di_o
);

  wr_state_e                state_q;
  logic                     awready_q;
  logic                     wready_q;
  logic                     bvalid_q;
  logic [`AXI_IDS_BITS-1:0] id_q;
  logic [`AXI_IDS_BITS-1:0] bid_q;
  logic [1:0]               bresp_q;
  logic                     err_q;

  logic aw_hs;
  logic w_hs;
  logic aw_err;
  logic len_err;
  logic early_last;

  assign aw_hs = awvalid_i & awready_q;
  assign w_hs  = (state_q == ST_WDATA) & wvalid_i & wready_q;

  assign aw_err = aw_illegal(awaddr_i, awlen_i, awsize_i, awburst_i,
                             BASE_ADDR, MEM_ADDR_BITS);

  axi_wr_resp_slave_wr_addr_gen #(
    .MEM_ADDR_BITS (MEM_ADDR_BITS)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .load_i       (aw_hs),
    .start_addr_i (awaddr_i[MEM_ADDR_BITS+1:2]),
    .len_i        (awlen_i),
    .burst_i      (awburst_i),
    .beat_i       (w_hs),
    .last_i       (wlast_i),
    .addr_o       (mem_addr_o),
    .len_err_o    (len_err),
    .early_last_o (early_last)
  );

  // A beat reaches the SRAM only while the burst is still clean; an early
  // WLAST beat is already known bad and is dropped
  assign mem_cs_o = w_hs & ~err_q & ~early_last;
  assign mem_we_o = mem_cs_o ? wstrb_i : 4'b0000;
  assign mem_di_o = wdata_i;

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bid_o     = bid_q;
  assign bresp_o   = bresp_q;

  // Transaction FSM with registered handshake and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      id_q      <= '0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            id_q      <= awid_i;
            err_q     <= aw_err;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            state_q   <= ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (w_hs) begin
            if (len_err) begin
              err_q <= 1'b1;
            end
            if (wlast_i) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= (err_q | len_err) ? RESP_SLVERR : RESP_OKAY;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (bvalid_q & bready_i) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_resp_slave.sv
// Directed bench for axi_wr_resp_slave with a byte-strobed SRAM model.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

module tb_axi_wr_resp_slave;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [1:0]  FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10;

  logic        clk;
  logic        rst;
  logic [7:0]  awid_i;
  logic [31:0] awaddr_i;
  logic [3:0]  awlen_i;
  logic [2:0]  awsize_i;
  logic [1:0]  awburst_i;
  logic        awvalid_i;
  logic        awready_o;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic        wlast_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [7:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i;
  logic        mem_cs_o;
  logic [3:0]  mem_we_o;
  logic [13:0] mem_addr_o;
  logic [31:0] mem_di_o;

  int checks = 0;
  int errors = 0;

  logic        clear_mem;
  logic [31:0] sram [0:16383];

  axi_wr_resp_slave #(
    .BASE_ADDR     (32'h0001_0000),
    .MEM_ADDR_BITS (14)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .awid_i     (awid_i),
    .awaddr_i   (awaddr_i),
    .awlen_i    (awlen_i),
    .awsize_i   (awsize_i),
    .awburst_i  (awburst_i),
    .awvalid_i  (awvalid_i),
    .awready_o  (awready_o),
    .wdata_i    (wdata_i),
    .wstrb_i    (wstrb_i),
    .wlast_i    (wlast_i),
    .wvalid_i   (wvalid_i),
    .wready_o   (wready_o),
    .bid_o      (bid_o),
    .bresp_o    (bresp_o),
    .bvalid_o   (bvalid_o),
    .bready_i   (bready_i),
    .mem_cs_o   (mem_cs_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_di_o   (mem_di_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: byte-enabled write captured on the clock edge
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 16384; i++) sram[i] <= 32'h0;
    end else if (mem_cs_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_di_o[8*b +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Present an AW and wait (bounded) for its handshake; returns at a negedge
  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    int n;
    awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size;
    awburst_i = burst; awvalid_i = 1'b1;
    n = 0;
    while (awready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (awready_o !== 1'b1) begin
      errors++;
      $display("FAIL aw_accept id=%h: awready_o=%b expected 1", id, awready_o);
    end
    @(negedge clk);
    awvalid_i = 1'b0;
    checks++;
    if (wready_o !== 1'b1 || awready_o !== 1'b0) begin
      errors++;
      $display("FAIL aw_latency id=%h: wready_o=%b awready_o=%b expected 1 0",
               id, wready_o, awready_o);
    end
  endtask

  // Present one W beat, check the SRAM port during the handshake cycle
  task automatic send_w(input logic [31:0] data, input logic [3:0] strb,
                        input logic last, input logic exp_cs,
                        input logic [13:0] exp_addr);
    int n;
    logic [3:0] exp_we;
    wdata_i = data; wstrb_i = strb; wlast_i = last; wvalid_i = 1'b1;
    exp_we = exp_cs ? strb : 4'h0;
    n = 0;
    #1;
    while (wready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (mem_cs_o !== exp_cs || mem_we_o !== exp_we ||
        (exp_cs && mem_addr_o !== exp_addr) || wready_o !== 1'b1) begin
      errors++;
      $display("FAIL w_beat data=%h: cs=%b we=%h addr=%h wready=%b expected cs=%b we=%h addr=%h wready=1",
               data, mem_cs_o, mem_we_o, mem_addr_o, wready_o, exp_cs, exp_we, exp_addr);
    end
    @(negedge clk);
    wvalid_i = 1'b0; wlast_i = 1'b0;
  endtask

  // Expect B the cycle after the last beat, then complete the handshake
  task automatic take_b(input logic [7:0] id, input logic [1:0] resp);
    checks++;
    if (bvalid_o !== 1'b1 || bid_o !== id || bresp_o !== resp) begin
      errors++;
      $display("FAIL b_resp: bvalid=%b bid=%h bresp=%b expected 1 %h %b",
               bvalid_o, bid_o, bresp_o, id, resp);
    end
    bready_i = 1'b1;
    @(negedge clk);
    bready_i = 1'b0;
    checks++;
    if (bvalid_o !== 1'b0 || awready_o !== 1'b1) begin
      errors++;
      $display("FAIL b_done id=%h: bvalid=%b awready=%b expected 0 1", id, bvalid_o, awready_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_mem = 1'b1;
    awid_i = 8'h0; awaddr_i = 32'h0; awlen_i = 4'h0; awsize_i = 3'b010;
    awburst_i = INCR; awvalid_i = 1'b0; wdata_i = 32'h0; wstrb_i = 4'h0;
    wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (awready_o !== 1'b0 || wready_o !== 1'b0 || bvalid_o !== 1'b0 ||
        bid_o !== 8'h00 || bresp_o !== OKAY || mem_cs_o !== 1'b0 || mem_we_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: aw=%b w=%b b=%b bid=%h bresp=%b cs=%b we=%h expected all 0",
               awready_o, wready_o, bvalid_o, bid_o, bresp_o, mem_cs_o, mem_we_o);
    end
    rst = 1'b0; clear_mem = 1'b0;
    checks++;
    if (awready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: awready_o=%b expected 0", awready_o);
    end
    // A W beat in IDLE must not be accepted
    wvalid_i = 1'b1; wlast_i = 1'b1; wstrb_i = 4'hF; wdata_i = 32'h5555_AAAA;
    @(negedge clk);
    checks++;
    if (awready_o !== 1'b1 || wready_o !== 1'b0 || mem_cs_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: awready=%b wready=%b cs=%b expected 1 0 0",
               awready_o, wready_o, mem_cs_o);
    end
    wvalid_i = 1'b0; wlast_i = 1'b0;
  endtask

  task automatic test_single();
    send_aw(8'h15, BASE + 32'h10, 4'd0, 3'b010, INCR);
    send_w(32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 14'd4);
    take_b(8'h15, OKAY);
    checks++;
    if (sram[4] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_mem: sram[4]=%h expected deadbeef", sram[4]);
    end
  endtask

  task automatic test_incr_burst();
    send_aw(8'h21, BASE, 4'd3, 3'b010, INCR);
    send_w(32'h1111_1111, 4'hF,    1'b0, 1'b1, 14'd0);
    send_w(32'h2222_2222, 4'hF,    1'b0, 1'b1, 14'd1);
    send_w(32'h3333_3333, 4'b0101, 1'b0, 1'b1, 14'd2);
    send_w(32'h4444_4444, 4'hF,    1'b1, 1'b1, 14'd3);
    take_b(8'h21, OKAY);
    checks++;
    if (sram[0] !== 32'h1111_1111 || sram[1] !== 32'h2222_2222 ||
        sram[2] !== 32'h0033_0033 || sram[3] !== 32'h4444_4444) begin
      errors++;
      $display("FAIL incr_mem: %h %h %h %h expected 11111111 22222222 00330033 44444444",
               sram[0], sram[1], sram[2], sram[3]);
    end
  endtask

  task automatic test_fixed_burst();
    send_aw(8'h32, BASE + 32'h8, 4'd2, 3'b010, FIXED);
    send_w(32'hA0A0_A0A0, 4'hF, 1'b0, 1'b1, 14'd2);
    send_w(32'hA1A1_A1A1, 4'hF, 1'b0, 1'b1, 14'd2);
    send_w(32'hA2A2_A2A2, 4'hF, 1'b1, 1'b1, 14'd2);
    take_b(8'h32, OKAY);
    checks++;
    if (sram[2] !== 32'hA2A2_A2A2 || sram[3] !== 32'h4444_4444) begin
      errors++;
      $display("FAIL fixed_mem: sram[2]=%h sram[3]=%h expected a2a2a2a2 44444444",
               sram[2], sram[3]);
    end
  endtask

  task automatic test_errors();
    // Narrow beat size
    send_aw(8'h61, BASE + 32'h100, 4'd0, 3'b001, INCR);
    send_w(32'hBAD0_0001, 4'hF, 1'b1, 1'b0, 14'd64);
    take_b(8'h61, SLVERR);
    // WRAP burst
    send_aw(8'h62, BASE + 32'h104, 4'd1, 3'b010, WRAP);
    send_w(32'hBAD0_0002, 4'hF, 1'b0, 1'b0, 14'd65);
    send_w(32'hBAD0_0003, 4'hF, 1'b1, 1'b0, 14'd66);
    take_b(8'h62, SLVERR);
    checks++;
    if (sram[64] !== 32'h0 || sram[65] !== 32'h0 || sram[66] !== 32'h0) begin
      errors++;
      $display("FAIL err_size_wrap_mem: %h %h %h expected 0 0 0", sram[64], sram[65], sram[66]);
    end
    // Below the window
    send_aw(8'h63, BASE - 32'd4, 4'd0, 3'b010, INCR);
    send_w(32'hBAD0_0004, 4'hF, 1'b1, 1'b0, 14'h3FFF);
    take_b(8'h63, SLVERR);
    // Burst running past the last window word
    send_aw(8'h64, BASE + 32'hFFFC, 4'd3, 3'b010, INCR);
    for (int i = 0; i < 4; i++)
      send_w(32'hBAD1_0000 + i, 4'hF, (i == 3), 1'b0, 14'h3FFF);
    take_b(8'h64, SLVERR);
    checks++;
    if (sram[16383] !== 32'h0 || sram[0] !== 32'h1111_1111) begin
      errors++;
      $display("FAIL err_window_mem: sram[3fff]=%h sram[0]=%h expected 0 11111111",
               sram[16383], sram[0]);
    end
    // Single beat at the last window word is legal
    send_aw(8'h67, BASE + 32'hFFFC, 4'd0, 3'b010, INCR);
    send_w(32'h600D_F00D, 4'hF, 1'b1, 1'b1, 14'h3FFF);
    take_b(8'h67, OKAY);
    checks++;
    if (sram[16383] !== 32'h600D_F00D) begin
      errors++;
      $display("FAIL last_word_mem: sram[3fff]=%h expected 600df00d", sram[16383]);
    end
    // Early WLAST on beat 1 of a 4-beat burst
    send_aw(8'h65, BASE + 32'h200, 4'd3, 3'b010, INCR);
    send_w(32'hC0C0_0000, 4'hF, 1'b0, 1'b1, 14'd128);
    send_w(32'hC0C0_0001, 4'hF, 1'b1, 1'b0, 14'd129);
    take_b(8'h65, SLVERR);
    checks++;
    if (sram[128] !== 32'hC0C0_0000 || sram[129] !== 32'h0) begin
      errors++;
      $display("FAIL early_last_mem: %h %h expected c0c00000 0", sram[128], sram[129]);
    end
    // Missing WLAST on the final counted beat
    send_aw(8'h66, BASE + 32'h240, 4'd0, 3'b010, INCR);
    send_w(32'hD0D0_0000, 4'hF, 1'b0, 1'b1, 14'd144);
    send_w(32'hD0D0_0001, 4'hF, 1'b1, 1'b0, 14'd145);
    take_b(8'h66, SLVERR);
    checks++;
    if (sram[144] !== 32'hD0D0_0000 || sram[145] !== 32'h0) begin
      errors++;
      $display("FAIL late_last_mem: %h %h expected d0d00000 0", sram[144], sram[145]);
    end
  endtask

  task automatic test_back_to_back();
    send_aw(8'h44, BASE + 32'h20, 4'd0, 3'b010, INCR);
    send_w(32'hCAFE_F00D, 4'hF, 1'b1, 1'b1, 14'd8);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bvalid_o !== 1'b1 || bid_o !== 8'h44 || bresp_o !== OKAY || awready_o !== 1'b0) begin
        errors++;
        $display("FAIL b_hold cycle %0d: bvalid=%b bid=%h bresp=%b awready=%b expected 1 44 00 0",
                 i, bvalid_o, bid_o, bresp_o, awready_o);
      end
      @(negedge clk);
    end
    // Next AW waiting while B completes
    awid_i = 8'h45; awaddr_i = BASE + 32'h24; awlen_i = 4'd0; awsize_i = 3'b010;
    awburst_i = INCR; awvalid_i = 1'b1; bready_i = 1'b1;
    @(negedge clk);
    bready_i = 1'b0;
    checks++;
    if (bvalid_o !== 1'b0 || awready_o !== 1'b1 || wready_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after_b: bvalid=%b awready=%b wready=%b expected 0 1 0",
               bvalid_o, awready_o, wready_o);
    end
    @(negedge clk);
    awvalid_i = 1'b0;
    checks++;
    if (wready_o !== 1'b1 || awready_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_aw_accept: wready=%b awready=%b expected 1 0", wready_o, awready_o);
    end
    send_w(32'h1234_5678, 4'hF, 1'b1, 1'b1, 14'd9);
    take_b(8'h45, OKAY);
    checks++;
    if (sram[8] !== 32'hCAFE_F00D || sram[9] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL b2b_mem: %h %h expected cafef00d 12345678", sram[8], sram[9]);
    end
  endtask

  task automatic test_reset_mid_burst();
    send_aw(8'h55, BASE + 32'h300, 4'd3, 3'b010, INCR);
    send_w(32'hE0E0_0000, 4'hF, 1'b0, 1'b1, 14'd192);
    send_w(32'hE0E0_0001, 4'hF, 1'b0, 1'b1, 14'd193);
    wdata_i = 32'hE0E0_0002; wstrb_i = 4'hF; wlast_i = 1'b0; wvalid_i = 1'b1;
    #1;
    checks++;
    if (mem_cs_o !== 1'b1 || mem_addr_o !== 14'd194) begin
      errors++;
      $display("FAIL beat2_before_rst: cs=%b addr=%h expected 1 0c2", mem_cs_o, mem_addr_o);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (mem_cs_o !== 1'b0 || mem_we_o !== 4'h0 || awready_o !== 1'b0 || wready_o !== 1'b0 ||
        bvalid_o !== 1'b0 || bid_o !== 8'h00 || bresp_o !== OKAY) begin
      errors++;
      $display("FAIL async_reset: cs=%b we=%h aw=%b w=%b b=%b bid=%h bresp=%b expected all 0",
               mem_cs_o, mem_we_o, awready_o, wready_o, bvalid_o, bid_o, bresp_o);
    end
    @(negedge clk);
    wvalid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (awready_o !== 1'b1 || bvalid_o !== 1'b0 || wready_o !== 1'b0) begin
      errors++;
      $display("FAIL after_mid_rst: awready=%b bvalid=%b wready=%b expected 1 0 0",
               awready_o, bvalid_o, wready_o);
    end
    checks++;
    if (sram[192] !== 32'hE0E0_0000 || sram[193] !== 32'hE0E0_0001 || sram[194] !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst_mem: %h %h %h expected e0e00000 e0e00001 0",
               sram[192], sram[193], sram[194]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_burst();
    test_fixed_burst();
    test_errors();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
